// File: rtl/ysyx_22050133_axi_pkg.sv
// Shared constants and FSM state type for the AXI read-channel arbiter.
package ysyx_22050133_axi_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_AR   = 2'd1;
    localparam logic [1:0] ARB_RD   = 2'd2;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [1:0] BURST_INCR    = 2'b01;

    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

    typedef enum logic [1:0] {
        StIdle = ARB_IDLE,
        StAr   = ARB_AR,
        StRd   = ARB_RD
    } arb_state_e;

endpackage

// File: rtl/ysyx_22050133_axi_rd_arb_if.sv
// AXI4 read-channel bundle (AR + R). The "master" modport issues AR and sinks R;
// the "slave" modport accepts AR and sources R.
interface ysyx_22050133_axi_rd_arb_if #(
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 4
) ();
    logic                      ar_valid;
    logic                      ar_ready;
    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;

    logic                      r_valid;
    logic                      r_ready;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [1:0]                r_resp;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic                      r_last;

    modport master (
        output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, r_ready,
        input  ar_ready, r_valid, r_id, r_resp, r_data, r_last
    );

    modport slave (
        input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, r_ready,
        output ar_ready, r_valid, r_id, r_resp, r_data, r_last
    );
endinterface

// File: rtl/ysyx_22050133_arb2.sv
// Two-way grant picker producing a one-hot grant. Fixed m1>m0 priority by default;
// round-robin tie-break when AXI_RD_ARB_RR_EN is defined.
module ysyx_22050133_arb2
    import ysyx_22050133_axi_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
`ifdef AXI_RD_ARB_RR_EN
        // On a tie the master that did not win last time goes first.
        if (req == 2'b11) begin
            gnt = (last_gnt == MST_LSU) ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
`else
        if (req[MST_LSU]) begin
            gnt = 2'b10;
        end else if (req[MST_IFU]) begin
            gnt = 2'b01;
        end
`endif
    end

`ifndef AXI_RD_ARB_RR_EN
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

endmodule

// File: rtl/ysyx_22050133_axi_rd_arb.sv
// 2:1 AXI4 read arbiter (m0 = IFU, m1 = LSU) granting one whole burst at a time.
// Define AXI_RD_ARB_RR_EN for round-robin tie-breaking instead of fixed m1>m0.
module ysyx_22050133_axi_rd_arb
    import ysyx_22050133_axi_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 4
) (
    input logic                         clk,
    input logic                         rst_n,
    ysyx_22050133_axi_rd_arb_if.slave   m0,
    ysyx_22050133_axi_rd_arb_if.slave   m1,
    ysyx_22050133_axi_rd_arb_if.master  s
);

    arb_state_e                state_q, state_d;
    logic                      gnt_q, gnt_d;
    logic [7:0]                beat_cnt_q, beat_cnt_d;
    logic                      ar_load;

    logic [AXI_ID_WIDTH-1:0]   ar_id_q;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr_q;
    logic [7:0]                ar_len_q;
    logic [2:0]                ar_size_q;
    logic [1:0]                ar_burst_q;

    logic [1:0]                req;
    logic [1:0]                win;
    logic                      last_gnt;
    logic                      r_ready_sel;
    logic                      r_hs;
    logic [AXI_DATA_WIDTH-1:0] r_data;

    assign req = {m1.ar_valid, m0.ar_valid};

    ysyx_22050133_arb2 u_arb2 (
        .req      (req),
        .last_gnt (last_gnt),
        .gnt      (win)
    );

`ifdef AXI_RD_ARB_RR_EN
    logic last_gnt_q;

    // Reset to LSU so the IFU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= MST_LSU;
        end else if (ar_load) begin
            last_gnt_q <= gnt_d;
        end
    end
    assign last_gnt = last_gnt_q;
`else
    assign last_gnt = MST_LSU;
`endif

    assign r_ready_sel = (gnt_q == MST_LSU) ? m1.r_ready : m0.r_ready;
    assign r_hs        = s.r_valid & r_ready_sel;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;
        ar_load    = 1'b0;
        m0.ar_ready = 1'b0;
        m1.ar_ready = 1'b0;
        s.ar_valid  = 1'b0;
        s.r_ready   = 1'b0;
        m0.r_valid  = 1'b0;
        m1.r_valid  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Ready is combinational, so hold it off while reset is asserted.
                m0.ar_ready = rst_n & win[MST_IFU];
                m1.ar_ready = rst_n & win[MST_LSU];
                if (rst_n && (req != 2'b00)) begin
                    ar_load = 1'b1;
                    gnt_d   = win[MST_LSU];
                    state_d = StAr;
                end
            end
            StAr: begin
                s.ar_valid = 1'b1;
                if (s.ar_ready) begin
                    beat_cnt_d = 8'd0;
                    state_d    = StRd;
                end
            end
            StRd: begin
                s.r_ready = r_ready_sel;
                if (gnt_q == MST_LSU) begin
                    m1.r_valid = s.r_valid;
                end else begin
                    m0.r_valid = s.r_valid;
                end
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (s.r_last) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            gnt_q      <= MST_IFU;
            beat_cnt_q <= 8'd0;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= 8'd0;
            ar_size_q  <= 3'd0;
            ar_burst_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
            if (ar_load) begin
                ar_id_q    <= win[MST_LSU] ? m1.ar_id    : m0.ar_id;
                ar_addr_q  <= win[MST_LSU] ? m1.ar_addr  : m0.ar_addr;
                ar_len_q   <= win[MST_LSU] ? m1.ar_len   : m0.ar_len;
                ar_size_q  <= win[MST_LSU] ? m1.ar_size  : m0.ar_size;
                ar_burst_q <= win[MST_LSU] ? m1.ar_burst : m0.ar_burst;
            end
        end
    end

    assign s.ar_id    = ar_id_q;
    assign s.ar_addr  = ar_addr_q;
    assign s.ar_len   = ar_len_q;
    assign s.ar_size  = ar_size_q;
    assign s.ar_burst = ar_burst_q;

    // R payload is broadcast; only the granted master sees r_valid.
    assign r_data    = s.r_data;
    assign m0.r_data = r_data;
    assign m1.r_data = r_data;
    assign m0.r_id   = s.r_id;
    assign m1.r_id   = s.r_id;
    assign m0.r_resp = s.r_resp;
    assign m1.r_resp = s.r_resp;
    assign m0.r_last = s.r_last;
    assign m1.r_last = s.r_last;

    last_beat_matches_len: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StRd && r_hs && s.r_last) |-> (beat_cnt_q == ar_len_q));

endmodule

// File: tb/tb_ysyx_22050133_axi_rd_arb.sv
// Randomized directed bench for the 2:1 AXI read arbiter; a request/grant model
// predicts the winner, AR payload and the beats each master should receive.
module tb_ysyx_22050133_axi_rd_arb;
    import ysyx_22050133_axi_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_22050133_axi_rd_arb_if m0_if ();
    ysyx_22050133_axi_rd_arb_if m1_if ();
    ysyx_22050133_axi_rd_arb_if s_if ();

    ysyx_22050133_axi_rd_arb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if)
    );

    int tests = 0;
    int fails = 0;

    bit          pending [2];
    logic [31:0] p_addr  [2];
    logic [7:0]  p_len   [2];
    logic [3:0]  p_id    [2];
    logic [2:0]  p_size  [2];
    bit          model_last = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mk_req(input int m, input logic [31:0] addr, input logic [7:0] len);
        pending[m] = 1'b1;
        p_addr[m]  = addr;
        p_len[m]   = len;
        p_id[m]    = 4'($urandom);
        p_size[m]  = 3'($urandom_range(0, 3));
    endtask

    task automatic rand_req(input int m);
        mk_req(m, $urandom, 8'($urandom_range(0, 3)));
    endtask

    task automatic drive_ar();
        m0_if.ar_valid = pending[0];
        m0_if.ar_addr  = p_addr[0];
        m0_if.ar_len   = p_len[0];
        m0_if.ar_id    = p_id[0];
        m0_if.ar_size  = p_size[0];
        m0_if.ar_burst = BURST_INCR;
        m1_if.ar_valid = pending[1];
        m1_if.ar_addr  = p_addr[1];
        m1_if.ar_len   = p_len[1];
        m1_if.ar_id    = p_id[1];
        m1_if.ar_size  = p_size[1];
        m1_if.ar_burst = BURST_INCR;
    endtask

    // Reference arbitration rule
    function automatic int pick();
        if (pending[0] && pending[1]) begin
`ifdef AXI_RD_ARB_RR_EN
            return model_last ? 0 : 1;
`else
            return 1;
`endif
        end
        return pending[1] ? 1 : 0;
    endfunction

    // One full transaction starting at a negedge with the DUT idle.
    task automatic round(input bit gaps, input bit stall, input int ar_delay,
                         input logic [1:0] ar_req_mask, input int abort_at,
                         input bit use_data0, input logic [63:0] data0);
        int          w;
        logic [31:0] w_addr;
        logic [7:0]  w_len;
        logic [3:0]  w_id;
        logic [2:0]  w_size;
        logic [63:0] beats[$];
        int          sent;
        int          cyc;
        logic        mready;
        if (!pending[0] && !pending[1]) rand_req($urandom_range(0, 1));
        drive_ar();
        #1;
        w = pick();
        chk("idle_ar_ready_m0", m0_if.ar_ready, 64'(w == 0));
        chk("idle_ar_ready_m1", m1_if.ar_ready, 64'(w == 1));
        w_addr = p_addr[w];
        w_len  = p_len[w];
        w_id   = p_id[w];
        w_size = p_size[w];
        @(negedge clk);
        pending[w] = 1'b0;
        model_last = (w == 1);
        for (int m = 0; m < 2; m++) if (ar_req_mask[m] && !pending[m]) rand_req(m);
        drive_ar();
        for (int i = 0; i <= ar_delay; i++) begin
            s_if.ar_ready = (i == ar_delay);
            #1;
            chk("s_ar_valid", s_if.ar_valid, 1);
            chk("s_ar_addr", s_if.ar_addr, w_addr);
            chk("s_ar_len", s_if.ar_len, w_len);
            chk("s_ar_id", s_if.ar_id, w_id);
            chk("s_ar_size", s_if.ar_size, w_size);
            chk("s_ar_burst", s_if.ar_burst, BURST_INCR);
            chk("ar_phase_ready_m0", m0_if.ar_ready, 0);
            chk("ar_phase_ready_m1", m1_if.ar_ready, 0);
            @(negedge clk);
        end
        s_if.ar_ready = 1'b0;
        for (int k = 0; k <= int'(w_len); k++)
            beats.push_back((use_data0 && k == 0) ? data0 : {$urandom, $urandom});
        sent = 0;
        cyc  = 0;
        while (sent <= int'(w_len) && cyc < 200) begin
            s_if.r_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_if.r_data  = beats[sent];
            s_if.r_last  = (sent == int'(w_len));
            s_if.r_id    = w_id;
            s_if.r_resp  = 2'($urandom);
            mready = (stall && cyc < 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (w == 1) begin
                m1_if.r_ready = mready;
                m0_if.r_ready = 1'($urandom);
            end else begin
                m0_if.r_ready = mready;
                m1_if.r_ready = 1'($urandom);
            end
            if (abort_at == sent) begin
                s_if.r_valid = 1'b1;
                rst_n = 1'b0;
                #1;
                chk("rst_mid_m0_r_valid", m0_if.r_valid, 0);
                chk("rst_mid_m1_r_valid", m1_if.r_valid, 0);
                chk("rst_mid_s_r_ready", s_if.r_ready, 0);
                chk("rst_mid_s_ar_valid", s_if.ar_valid, 0);
                chk("rst_mid_s_ar_addr", s_if.ar_addr, 0);
                chk("rst_mid_m0_ar_ready", m0_if.ar_ready, 0);
                chk("rst_mid_m1_ar_ready", m1_if.ar_ready, 0);
                @(negedge clk);
                rst_n = 1'b1;
                s_if.r_valid = 1'b0;
                s_if.r_last  = 1'b0;
                model_last = 1'b1;
                return;
            end
            #1;
            chk("r_valid_granted", (w == 1) ? m1_if.r_valid : m0_if.r_valid, s_if.r_valid);
            chk("r_valid_other", (w == 1) ? m0_if.r_valid : m1_if.r_valid, 0);
            chk("s_r_ready", s_if.r_ready, mready);
            chk("rd_ar_ready_m0", m0_if.ar_ready, 0);
            chk("rd_ar_ready_m1", m1_if.ar_ready, 0);
            if (s_if.r_valid) begin
                chk("r_data", (w == 1) ? m1_if.r_data : m0_if.r_data, beats[sent]);
                chk("r_last", (w == 1) ? m1_if.r_last : m0_if.r_last, 64'(sent == int'(w_len)));
                chk("r_id", (w == 1) ? m1_if.r_id : m0_if.r_id, w_id);
                chk("r_resp", (w == 1) ? m1_if.r_resp : m0_if.r_resp, s_if.r_resp);
            end
            if (s_if.r_valid && mready) sent++;
            cyc++;
            @(negedge clk);
        end
        s_if.r_valid = 1'b0;
        s_if.r_last  = 1'b0;
        if (sent <= int'(w_len)) chk("burst_timeout", 64'(sent), 64'(w_len) + 1);
    endtask

    initial begin
        pending[0] = 1'b0;
        pending[1] = 1'b0;
        for (int m = 0; m < 2; m++) begin
            p_addr[m] = '0; p_len[m] = '0; p_id[m] = '0; p_size[m] = '0;
        end
        drive_ar();
        m0_if.r_ready = 1'b0;
        m1_if.r_ready = 1'b0;
        s_if.ar_ready = 1'b0;
        s_if.r_valid  = 1'b0;
        s_if.r_id     = '0;
        s_if.r_resp   = AXI_RESP_OKAY;
        s_if.r_data   = '0;
        s_if.r_last   = 1'b0;

        // Reset state, with both masters requesting to exercise ready gating
        m0_if.ar_valid = 1'b1;
        m1_if.ar_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_m0_ar_ready", m0_if.ar_ready, 0);
        chk("rst_m1_ar_ready", m1_if.ar_ready, 0);
        chk("rst_s_ar_valid", s_if.ar_valid, 0);
        chk("rst_s_ar_addr", s_if.ar_addr, 0);
        chk("rst_s_ar_len", s_if.ar_len, 0);
        chk("rst_m0_r_valid", m0_if.r_valid, 0);
        chk("rst_m1_r_valid", m1_if.r_valid, 0);
        chk("rst_s_r_ready", s_if.r_ready, 0);
        m0_if.ar_valid = 1'b0;
        m1_if.ar_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_noreq_m0_ready", m0_if.ar_ready, 0);
            chk("idle_noreq_m1_ready", m1_if.ar_ready, 0);
            chk("idle_noreq_s_ar_valid", s_if.ar_valid, 0);
        end

        // Single m0 request, single beat
        mk_req(0, 32'h8000_0000, 8'd0);
        round(1'b0, 1'b0, 0, 2'b00, -1, 1'b1, 64'hDEAD);

        // Simultaneous requests, then the loser follows after one idle cycle
        mk_req(0, $urandom, 8'd1);
        mk_req(1, $urandom, 8'd1);
        round(1'b0, 1'b0, 0, 2'b00, -1, 1'b0, 64'h0);
        round(1'b0, 1'b0, 0, 2'b00, -1, 1'b0, 64'h0);

        // Both masters kept requesting for four grants
        for (int i = 0; i < 4; i++) begin
            for (int m = 0; m < 2; m++) if (!pending[m]) rand_req(m);
            round(1'b0, 1'b0, 0, 2'b00, -1, 1'b0, 64'h0);
        end
        while (pending[0] || pending[1]) round(1'b0, 1'b0, 0, 2'b00, -1, 1'b0, 64'h0);

        // m1 4-beat burst with gaps and an initial master stall
        mk_req(1, $urandom, 8'd3);
        round(1'b1, 1'b1, 0, 2'b00, -1, 1'b0, 64'h0);

        // Slave holds off AR for 5 cycles while m0 raises a new request
        mk_req(1, $urandom, 8'd0);
        round(1'b0, 1'b0, 5, 2'b01, -1, 1'b0, 64'h0);
        while (pending[0] || pending[1]) round(1'b0, 1'b0, 0, 2'b00, -1, 1'b0, 64'h0);

        // Reset mid-burst, then m0 is granted cleanly
        mk_req(1, $urandom, 8'd3);
        round(1'b0, 1'b0, 0, 2'b01, 2, 1'b0, 64'h0);
        chk("post_rst_m0_pending", 64'(pending[0]), 1);
        round(1'b0, 1'b0, 0, 2'b00, -1, 1'b0, 64'h0);

        // Random traffic
        for (int i = 0; i < 24; i++) begin
            for (int m = 0; m < 2; m++) if (!pending[m] && $urandom_range(0, 1) == 1) rand_req(m);
            round(1'($urandom), 1'($urandom), $urandom_range(0, 3),
                  2'($urandom), -1, 1'b0, 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
